// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Results appear in a held output register at the DONE entry edge.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  // Full adder built from two half adders on the current LSBs.
  logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;
  assign ha1_s = a_reg[0] ^ b_reg[0];
  assign ha1_c = a_reg[0] & b_reg[0];
  assign fa_s  = ha1_s ^ carry_reg;
  assign ha2_c = ha1_s & carry_reg;
  assign fa_c  = ha1_c | ha2_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    sum_next   = sum_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is A + ~B with the borrow folded into the initial carry.
          a_next     = a;
          b_next     = sub ? ~b : b;
          carry_next = cin ^ sub;
          res_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end

      RUN: begin
        a_next     = {1'b0, a_reg[WIDTH-1:1]};
        b_next     = {1'b0, b_reg[WIDTH-1:1]};
        res_next   = {fa_s, res_reg[WIDTH-1:1]};
        carry_next = fa_c;
        if (cnt_reg == LAST_BIT) begin
          // carry_reg here is the carry into the MSB.
          sum_next   = {fa_s, res_reg[WIDTH-1:1]};
          cout_next  = fa_c;
          ovf_next   = carry_reg ^ fa_c;
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder: directed corner cases plus random
// operations, checked against an integer-arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W+1:0] res;   // {ovf, cout, sum}
    int           cyc;   // clock edge count at which done must be visible
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  logic [W+1:0] held = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain unsigned/signed integer arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, rb,
                                          input logic rc, rs);
    int ua, ub, sa, sb_i, u, s;
    logic signed [W-1:0] ta, tb;
    logic [W-1:0] r;
    logic co, ov;
    ta = ra; tb = rb;
    ua = int'(ra); ub = int'(rb);
    sa = int'(ta); sb_i = int'(tb);
    if (!rs) begin
      u  = ua + ub + int'(rc);
      s  = sa + sb_i + int'(rc);
      co = (u >= (1 << W));
    end else begin
      u  = ua - ub - int'(rc);
      s  = sa - sb_i - int'(rc);
      co = (u >= 0);
    end
    r  = u[W-1:0];
    ov = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    return {ov, co, r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("result", {ovf, cout, sum}, e.res);
          chk("latency", cyc, e.cyc);
          held = e.res;
          $display("txn a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d",
                   e.a, e.b, e.cin, e.sub, sum, cout, ovf);
        end
      end else if (!rst && busy) begin
        chk("hold_during_run", {ovf, cout, sum}, held);
      end
    end
  endtask

  task automatic issue(input logic [W-1:0] ia, ib, input logic ic, is, input bit push);
    exp_t e;
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    if (push) begin
      e.a = ia; e.b = ib; e.cin = ic; e.sub = is;
      e.res = ref_op(ia, ib, ic, is);
      e.cyc = cyc + 1 + W;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
  endtask

  task automatic run_op(input logic [W-1:0] ia, ib, input logic ic, is);
    bit ok;
    issue(ia, ib, ic, is, 1'b1);
    wait_done(W + 6, ok);
  endtask

  initial begin
    bit ok;
    int bc, d1, d2, dc0;
    exp_t e;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    fork
      monitor();
    join_none
    #1 rst = 1'b1;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", {ovf, cout, sum}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Carry chain with busy-length check.
    issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
    bc = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    chk("busy_cycles", bc, W);
    @(negedge clk);

    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    run_op(8'h7F, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    run_op(8'h05, 8'h07, 1'b0, 1'b1);
    @(negedge clk);
    run_op(8'h80, 8'h01, 1'b0, 1'b1);
    @(negedge clk);

    // Start while busy is ignored.
    dc0 = done_cnt;
    issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    issue(8'hAA, 8'h01, 1'b0, 1'b0, 1'b0);
    repeat (W + 6) @(negedge clk);
    chk("single_done", done_cnt - dc0, 1);

    // Back-to-back: start held high through DONE.
    issue(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0;
    wait_done(W + 6, ok);
    d1 = cyc;
    e.a = 8'h10; e.b = 8'h20; e.cin = 1'b0; e.sub = 1'b0;
    e.res = ref_op(8'h10, 8'h20, 1'b0, 1'b0);
    e.cyc = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done(W + 6, ok);
    d2 = cyc;
    chk("b2b_gap", d2 - d1, W + 1);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    issue(8'h55, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    held = '0;
    start = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", {ovf, cout, sum}, 0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0);
    @(negedge clk);

    // Random operations with occasional zero-gap restarts.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (W + 4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in for add, borrow-in for subtract.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 = A+B+cin; 1 = A-B-cin.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of the MSB (for subtract, 1 = no borrow).
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 IDLE: start=1 at an edge SHALL capture a, b, cin and sub, set busy=1 and enter RUN. start=0 SHALL leave the state and outputs unchanged.
REQ-017 On capture, the internal B register SHALL load sub ? ~b : b, and the carry flip-flop SHALL load cin ^ sub.
REQ-018 RUN: each cycle SHALL process one bit, LSB first, using a full-adder (half-adder pair) on A[i], B'[i] and carry. The sum bit SHALL shift into the result register, and the carry flip-flop SHALL update.
REQ-019 A bit counter of width clog2(WIDTH) SHALL count 0..WIDTH-1. At the edge that processes bit WIDTH-1, the FSM SHALL enter DONE.
REQ-020 Latency: if start is sampled at edge E0, done SHALL be 1 during the cycle after edge E0+WIDTH. busy SHALL be 1 from E0 until E0+WIDTH, exactly WIDTH cycles.
REQ-021 At the DONE entry edge, the block SHALL update sum, cout (final carry) and ovf (carry into MSB XOR carry out of MSB) together.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE. If start=1 in the DONE cycle, the block SHALL capture the new operands and go directly to RUN.
REQ-023 start SHALL be ignored while busy=1; the operands in flight SHALL remain unaffected.
REQ-024 sum, cout and ovf SHALL hold their last result until the next DONE entry. They SHALL NOT change during RUN; the result is built in a separate shift register.
REQ-025 a, b, cin and sub SHALL be don't-care except at the capture edge.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter, carry and operand registers.
REQ-027 rst asserted mid-RUN SHALL abort the operation without producing a done pulse. After rst deasserts, the first start SHALL run normally with the full WIDTH-cycle latency.
REQ-028 A start coincident with rst=1 SHALL be ignored.

Verification (WIDTH=8)
REQ-029 The bench SHALL cover add carry chain: a=0x0F, b=0x01, cin=0, sub=0 -> sum=0x10, cout=0, ovf=0; done 8 cycles after the start edge, busy high exactly 8 cycles.
REQ-030 The bench SHALL cover wrap-around: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Also a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-031 The bench SHALL cover subtract: sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0. Also sub=1, a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1.
REQ-032 The bench SHALL cover start during busy: start a=0x01, b=0x01; pulse start with a=0xAA at cycle 3 -> result sum=0x02, with a single done pulse.
REQ-033 The bench SHALL cover back-to-back operation: start held high through DONE with new operands 0x10+0x20 -> second done exactly 9 cycles after the first, sum=0x30.
REQ-034 The bench SHALL cover reset mid-run: assert rst asynchronously at cycle 4 of RUN -> all outputs 0 immediately and no done. Then 0x03+0x04 -> sum=0x07 after 8 cycles.
